// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MUL_DIV_UNIT_DIV_EN to build the divider; without it DIV/DIVU complete immediately as no-ops.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg;
  logic [5:0]         cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   op_b_reg;
  logic               sign_q_reg;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] fix_next;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH-1:0]   op_a_reg;
  logic               sign_r_reg;
  logic               dz_reg;
  logic               is_div_reg;
  logic [WIDTH:0]     div_rem;
  logic               div_borrow;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
`else
  logic               skip_reg;
`endif

  assign is_signed = ~op[2] & ~op[0];
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, op_b_reg};
    mul_next  = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]} : {1'b0, acc_reg[2*WIDTH-1:1]};
    step_next = mul_next;
    fix_next  = sign_q_reg ? -acc_reg : acc_reg;
`ifdef MUL_DIV_UNIT_DIV_EN
    div_rem    = acc_reg[2*WIDTH-1:WIDTH-1];
    div_borrow = div_rem < {1'b0, op_b_reg};
    div_diff   = div_rem[WIDTH-1:0] - op_b_reg;
    div_next   = div_borrow ? {div_rem[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                            : {div_diff, acc_reg[WIDTH-2:0], 1'b1};
    if (is_div_reg) begin
      step_next = div_next;
      if (dz_reg)
        fix_next = {(sign_r_reg ? -op_a_reg : op_a_reg), {WIDTH{1'b1}}};
      else
        fix_next = {(sign_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH]),
                    (sign_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0])};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      op_b_reg   <= '0;
      sign_q_reg <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
      op_a_reg   <= '0;
      sign_r_reg <= 1'b0;
      dz_reg     <= 1'b0;
      is_div_reg <= 1'b0;
`else
      skip_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // the done-pulse cycle still belongs to the finished operation
          if (start && !done) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc_reg    <= {{WIDTH{1'b0}}, mag_a};
                op_b_reg   <= mag_b;
                sign_q_reg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                busy       <= 1'b1;
                state_reg  <= CALC;
`ifdef MUL_DIV_UNIT_DIV_EN
                is_div_reg <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                acc_reg    <= {{WIDTH{1'b0}}, mag_a};
                op_a_reg   <= mag_a;
                op_b_reg   <= mag_b;
                sign_q_reg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r_reg <= is_signed & a[WIDTH-1];
                dz_reg     <= (b == '0);
                is_div_reg <= 1'b1;
                busy       <= 1'b1;
                state_reg  <= CALC;
`else
                done       <= 1'b1;
                skip_reg   <= 1'b1;
                state_reg  <= DONE;
`endif
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_reg <= step_next;
          if (cnt_reg == 6'(WIDTH - 1)) begin
            cnt_reg   <= '0;
            state_reg <= FIX;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        FIX: begin
          acc_reg   <= fix_next;
          state_reg <= DONE;
        end
        DONE: begin
`ifdef MUL_DIV_UNIT_DIV_EN
          hi   <= acc_reg[2*WIDTH-1:WIDTH];
          lo   <= acc_reg[WIDTH-1:0];
          done <= 1'b1;
`else
          if (!skip_reg) begin
            hi   <= acc_reg[2*WIDTH-1:WIDTH];
            lo   <= acc_reg[WIDTH-1:0];
            done <= 1'b1;
          end
          skip_reg <= 1'b0;
`endif
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin an operation, taken from op.
REQ-006 op  input  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-007 a  input  32  operand A (rs), driven by the A latch.
REQ-008 b  input  32  operand B (rt), driven by the B latch.
REQ-009 busy  output  1  high while a multiply or divide is in progress.
REQ-010 done  output  1  one-cycle pulse when HI and LO take a multiply or divide result.
REQ-011 hi  output  32  HI register; the datapath feeds it to the ALUOut latch for MFHI.
REQ-012 lo  output  32  LO register; the datapath feeds it to the ALUOut latch for MFLO.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, when start=1 and op is MULT, MULTU, DIV or DIVU, the block SHALL capture a, b and op, move to CALC, and raise busy from the next cycle.
REQ-015 In IDLE, when start=1 and op is MTHI or MTLO, the block SHALL write a into hi or lo at that edge, stay in IDLE, and leave busy and done low.
REQ-016 In IDLE, start=1 with a reserved op SHALL be ignored.
REQ-017 Signed ops SHALL convert operands to magnitudes at capture and record the result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
REQ-018 CALC SHALL run exactly 32 cycles, one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; a 6-bit counter tracks the steps.
REQ-019 FIX SHALL last 1 cycle and apply the two's-complement sign correction: to the 64-bit product, or to quotient and remainder separately.
REQ-020 DONE SHALL last 1 cycle: hi/lo are loaded (multiply: HI=product[63:32], LO=product[31:0]; divide: HI=remainder, LO=quotient), done=1, busy=0, and the next state is IDLE.
REQ-021 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+34, and hi/lo SHALL hold the new values in that same cycle.
REQ-022 start SHALL be ignored while busy=1, including MTHI and MTLO; a second start in the DONE cycle SHALL also be ignored.
REQ-023 Divide by zero (b=0) SHALL take full latency and give LO=32'hFFFFFFFF and HI=a (the original signed value), with no sign correction.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0, wrapping modulo 2^32.
REQ-025 hi/lo SHALL change only in DONE, at an accepted MTHI/MTLO, or at reset; partial results SHALL never be visible on hi/lo.

Reset
REQ-026 With rst=0 at a rising edge: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and all internal operand and accumulator registers=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse and clear hi/lo to 0.
REQ-028 On the first edge after rst returns to 1, the block SHALL be able to accept start.

Configuration
REQ-029 Macro MUL_DIV_UNIT_DIV_EN: when defined, DIV and DIVU SHALL behave as specified above.
REQ-030 When MUL_DIV_UNIT_DIV_EN is not defined, no divider logic SHALL be built: DIV and DIVU SHALL go IDLE->DONE, pulse done in the cycle after the accept edge, leave hi/lo unchanged, and keep busy low.

Verification
REQ-031 MULTU a=FFFFFFFF, b=FFFFFFFF -> done 34 cycles after accept; HI=FFFFFFFE, LO=00000001.
REQ-032 MULT a=FFFFFFFF (-1), b=00000002 -> HI=FFFFFFFF, LO=FFFFFFFE.
REQ-033 DIV a=FFFFFFF9 (-7), b=00000002 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1); DIVU a=00000064, b=00000007 -> LO=0000000E, HI=00000002.
REQ-034 DIVU a=12345678, b=0 -> LO=FFFFFFFF, HI=12345678, full latency.
REQ-035 MTHI a=AAAA5555 while busy -> ignored, HI ends with the multiply result; MTLO a=0000BEEF in IDLE -> LO=0000BEEF at the next cycle, done stays low.
REQ-036 Assert rst=0 at CALC step 10 of a MULT -> busy=0, hi=lo=0, no done pulse; a new MULTU 3*5 after release -> LO=0000000F, HI=0.
